// File: rtl/vgarcade_pkg.sv
// Shared types and constants for the vgarcade pixel-path blocks.
package vgarcade_pkg;

   localparam int unsigned COLOR_W = 12;
   localparam int unsigned PIX_W   = 10;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BLANK_CODE = 4'hF;

endpackage

// File: rtl/digit_glyph_rom.sv
// 16-entry 1bpp glyph ROM: seven-segment style digits 0-9, codes 10-15 blank.
// Address {code,row,col} is registered; the pixel bit is read combinationally from it.
module digit_glyph_rom
   import vgarcade_pkg::*;
#(
   parameter int unsigned GLYPH_SIZE = 32,
   parameter int unsigned GL         = $clog2(GLYPH_SIZE)
) (
   input  logic          clk,
   input  bcd_digit_t    code,
   input  logic [GL-1:0] row,
   input  logic [GL-1:0] col,
   output logic          lit
);

   bcd_digit_t    code_q;
   logic [GL-1:0] row_q;
   logic [GL-1:0] col_q;

   always_ff @(posedge clk) begin
      code_q <= code;
      row_q  <= row;
      col_q  <= col;
   end

   // Glyph drawn on a 16x16 unit grid; true when v falls in units [lo, hi).
   function automatic logic in_rng(input logic [GL-1:0] v, input int unsigned lo,
                                   input int unsigned hi);
      int unsigned s;
      s = 32'(v) * 16;
      return (s >= lo * GLYPH_SIZE) && (s < hi * GLYPH_SIZE);
   endfunction

   (* rom_style = "distributed" *) logic [6:0] seg_mask;
   logic [6:0] seg_hit;

   always_comb begin
      case (code_q)
         4'd0:    seg_mask = 7'b1111110;
         4'd1:    seg_mask = 7'b0110000;
         4'd2:    seg_mask = 7'b1101101;
         4'd3:    seg_mask = 7'b1111001;
         4'd4:    seg_mask = 7'b0110011;
         4'd5:    seg_mask = 7'b1011011;
         4'd6:    seg_mask = 7'b1011111;
         4'd7:    seg_mask = 7'b1110000;
         4'd8:    seg_mask = 7'b1111111;
         4'd9:    seg_mask = 7'b1111011;
         default: seg_mask = 7'b0000000;
      endcase
   end

   // Segment order {a,b,c,d,e,f,g}
   always_comb begin
      seg_hit[6] = in_rng(row_q, 1, 3)   && in_rng(col_q, 4, 12);
      seg_hit[5] = in_rng(col_q, 11, 13) && in_rng(row_q, 2, 8);
      seg_hit[4] = in_rng(col_q, 11, 13) && in_rng(row_q, 8, 14);
      seg_hit[3] = in_rng(row_q, 13, 15) && in_rng(col_q, 4, 12);
      seg_hit[2] = in_rng(col_q, 3, 5)   && in_rng(row_q, 8, 14);
      seg_hit[1] = in_rng(col_q, 3, 5)   && in_rng(row_q, 2, 8);
      seg_hit[0] = in_rng(row_q, 7, 9)   && in_rng(col_q, 4, 12);
   end

   assign lit = |(seg_mask & seg_hit);

endmodule

// File: rtl/score_digit_renderer.sv
// N-digit BCD score counter with per-frame snapshot and 2-stage glyph overlay pipeline.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits in the displayed value.
module score_digit_renderer
   import vgarcade_pkg::*;
#(
   parameter int unsigned       NUM_DIGITS = 3,
   parameter int unsigned       GLYPH_SIZE = 32,
   parameter int unsigned       SCALE_LOG2 = 0,
   parameter int unsigned       X0         = 16,
   parameter int unsigned       Y0         = 16,
   parameter logic [COLOR_W-1:0] FG_COLOR  = 12'hFFF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PIX_W-1:0]        pixel_x,
   input  logic [PIX_W-1:0]        pixel_y,
   input  logic                    video_on,
   input  logic                    inc,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] score_bcd,
   output logic                    saturated,
   output logic                    pixel_on,
   output logic [COLOR_W-1:0]      rgb
);

   localparam int unsigned GL        = $clog2(GLYPH_SIZE);
   localparam int unsigned CELL_LOG2 = GL + SCALE_LOG2;
   localparam int unsigned CW        = PIX_W + 1;
   localparam logic [CW-1:0] BOX_W   = CW'((NUM_DIGITS * GLYPH_SIZE) << SCALE_LOG2);
   localparam logic [CW-1:0] BOX_H   = CW'(GLYPH_SIZE << SCALE_LOG2);

   bcd_digit_t [NUM_DIGITS-1:0] score_q, score_d;
   bcd_digit_t [NUM_DIGITS-1:0] disp_q, disp_d;
   logic                        saturated_q;

   function automatic logic all_nines(input bcd_digit_t [NUM_DIGITS-1:0] v);
      logic r;
      r = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) r = r & (v[i] == 4'd9);
      return r;
   endfunction

   always_comb begin
      logic carry;
      score_d = score_q;
      carry   = 1'b1;
      if (clr) begin
         score_d = '0;
      end else if (inc && !all_nines(score_q)) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (carry) begin
               if (score_q[i] == 4'd9) begin
                  score_d[i] = 4'd0;
               end else begin
                  score_d[i] = score_q[i] + 4'd1;
                  carry      = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
      logic lead;
      lead   = 1'b1;
      disp_d = score_q;
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
         if (lead && score_q[i] == 4'd0) disp_d[i] = BLANK_CODE;
         else                            lead      = 1'b0;
      end
`else
      disp_d = score_q;
`endif
   end

   // Snapshot at the top-left pixel so a frame never shows a mid-frame score change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score_q     <= '0;
         saturated_q <= 1'b0;
         disp_q      <= '0;
      end else begin
         score_q     <= score_d;
         saturated_q <= all_nines(score_d);
         if (pixel_x == '0 && pixel_y == '0) disp_q <= disp_d;
      end
   end

   // Stage 1: box hit, slot decode and glyph address (11-bit subtraction, no wrap hits).
   logic [CW-1:0] dx, dy, slot;
   logic          hit_d, hit_q;
   bcd_digit_t    code_d;
   logic [GL-1:0] row_d, col_d;
   logic          rom_lit;
   logic          pixel_on_q;
   logic [COLOR_W-1:0] rgb_q;

   always_comb begin
      dx     = {1'b0, pixel_x} - CW'(X0);
      dy     = {1'b0, pixel_y} - CW'(Y0);
      hit_d  = video_on && (dx < BOX_W) && (dy < BOX_H);
      slot   = dx >> CELL_LOG2;
      row_d  = dy[SCALE_LOG2 +: GL];
      col_d  = dx[SCALE_LOG2 +: GL];
      code_d = BLANK_CODE;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (slot == CW'(int'(NUM_DIGITS) - 1 - i)) code_d = disp_q[i];
      end
   end

   digit_glyph_rom #(
      .GLYPH_SIZE (GLYPH_SIZE),
      .GL         (GL)
   ) u_rom (
      .clk  (clk),
      .code (code_d),
      .row  (row_d),
      .col  (col_d),
      .lit  (rom_lit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_q      <= 1'b0;
         pixel_on_q <= 1'b0;
         rgb_q      <= '0;
      end else begin
         hit_q      <= hit_d;
         pixel_on_q <= hit_q && rom_lit;
         rgb_q      <= (hit_q && rom_lit) ? FG_COLOR : '0;
      end
   end

   assign score_bcd = score_q;
   assign saturated = saturated_q;
   assign pixel_on  = pixel_on_q;
   assign rgb       = rgb_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer: score counter checks plus a pixel scoreboard
// that expects each driven pixel's result 2 clocks later. Honours LEAD_ZERO_BLANK_EN.
module tb_score_digit_renderer;
   import vgarcade_pkg::*;

   localparam logic [11:0] FG = 12'hFFF;
`ifdef LEAD_ZERO_BLANK_EN
   localparam logic BLANK_LEAD = 1'b1;
`else
   localparam logic BLANK_LEAD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  pixel_x, pixel_y;
   logic        video_on, inc, clr;
   logic [11:0] score_bcd;
   logic        saturated, pixel_on;
   logic [11:0] rgb;

   int n_tests = 0;
   int n_fail  = 0;
   int step    = 0;

   typedef struct packed {
      logic        on;
      logic [11:0] rgb;
      logic [15:0] id;
   } exp_t;
   exp_t exp_q[$];

   logic drv_valid = 1'b0;
   logic v1, v2;

   score_digit_renderer dut (
      .clk       (clk),
      .reset     (reset),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .video_on  (video_on),
      .inc       (inc),
      .clr       (clr),
      .score_bcd (score_bcd),
      .saturated (saturated),
      .pixel_on  (pixel_on),
      .rgb       (rgb)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= drv_valid;
         v2 <= v1;
      end
   end

   // Pixel results surface two rising edges after the pixel was driven.
   always @(negedge clk) begin
      if (v2) begin
         exp_t e;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL pix_queue: observed empty scoreboard, required a pending entry");
         end else begin
            e = exp_q.pop_front();
            assert (pixel_on === e.on && rgb === e.rgb) else begin
               n_fail++;
               $error("FAIL pix%0d: observed on=%b rgb=%h, required on=%b rgb=%h",
                      e.id, pixel_on, rgb, e.on, e.rgb);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, required %0h", tag, got, want);
      end
   endtask

   task automatic px(input int x, input int y, input logic von, input logic on);
      @(negedge clk);
      pixel_x   = 10'(x);
      pixel_y   = 10'(y);
      video_on  = von;
      drv_valid = 1'b1;
      step++;
      exp_q.push_back('{on: on, rgb: on ? FG : 12'h000, id: 16'(step)});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pixel_x   = 10'd500;
         pixel_y   = 10'd500;
         video_on  = 1'b0;
         drv_valid = 1'b0;
      end
   endtask

   task automatic pulse_inc(input int n);
      idle(1);
      inc = 1'b1;
      repeat (n) @(negedge clk);
      inc = 1'b0;
   endtask

   initial begin
      reset = 1'b1; inc = 1'b0; clr = 1'b0; video_on = 1'b0;
      pixel_x = 10'd500; pixel_y = 10'd500;
      repeat (3) @(negedge clk);
      chk("rst_score", 24'(score_bcd), 24'h000);
      chk("rst_sat", 24'(saturated), 24'h0);
      chk("rst_rgb", 24'(rgb), 24'h000);
      chk("rst_on", 24'(pixel_on), 24'h0);
      reset = 1'b0;
      idle(2);

      // Idle: video off gives black everywhere.
      px(32, 19, 1'b0, 1'b0);
      px(96, 32, 1'b0, 1'b0);
      px(64, 19, 1'b0, 1'b0);
      idle(3);

      // Score 3: display only follows after (0,0) is sampled.
      pulse_inc(3);
      chk("score3", 24'(score_bcd), 24'h003);
      px(96, 32, 1'b1, 1'b0);
      px(0, 0, 1'b1, 1'b0);
      px(96, 32, 1'b1, 1'b1);
      px(96, 19, 1'b1, 1'b1);
      px(32, 19, 1'b1, !BLANK_LEAD);
      px(32, 19, 1'b0, 1'b0);
      px(112, 32, 1'b1, 1'b0);
      px(15, 19, 1'b1, 1'b0);
      px(96, 15, 1'b1, 1'b0);
      idle(3);

      // Score 7: leading-zero slots.
      pulse_inc(4);
      chk("score7", 24'(score_bcd), 24'h007);
      px(0, 0, 1'b1, 1'b0);
      px(32, 19, 1'b1, !BLANK_LEAD);
      px(64, 19, 1'b1, !BLANK_LEAD);
      px(96, 19, 1'b1, 1'b1);
      px(96, 32, 1'b1, 1'b0);
      idle(3);

      // Mid-frame change must not tear.
      pulse_inc(1);
      chk("score8", 24'(score_bcd), 24'h008);
      px(96, 32, 1'b1, 1'b0);
      px(0, 0, 1'b1, 1'b0);
      px(96, 32, 1'b1, 1'b1);
      idle(3);

      // Score 42, then async reset mid-frame.
      pulse_inc(34);
      chk("score42", 24'(score_bcd), 24'h042);
      px(0, 0, 1'b1, 1'b0);
      idle(3);
      @(negedge clk);
      pixel_x = 10'd96; pixel_y = 10'd32; video_on = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("pre_rst_rgb", 24'(rgb), 24'(FG));
      #1 reset = 1'b1;
      #1;
      chk("async_score", 24'(score_bcd), 24'h000);
      chk("async_rgb", 24'(rgb), 24'h000);
      chk("async_on", 24'(pixel_on), 24'h0);
      @(negedge clk);
      video_on = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      px(0, 0, 1'b1, 1'b0);
      px(96, 32, 1'b1, 1'b0);
      px(96, 19, 1'b1, 1'b1);
      px(32, 19, 1'b1, !BLANK_LEAD);
      idle(3);

      // Saturation at 999 and clr priority.
      for (int k = 1; k <= 999; k++) begin
         pulse_inc(1);
         if (k == 10)  chk("carry10", 24'(score_bcd), 24'h010);
         if (k == 100) chk("carry100", 24'(score_bcd), 24'h100);
         if (k == 998) chk("sat998", 24'(saturated), 24'h0);
      end
      chk("score999", 24'(score_bcd), 24'h999);
      chk("sat999", 24'(saturated), 24'h1);
      pulse_inc(1);
      chk("hold999", 24'(score_bcd), 24'h999);
      chk("hold_sat", 24'(saturated), 24'h1);
      @(negedge clk);
      clr = 1'b1; inc = 1'b1;
      @(negedge clk);
      clr = 1'b0; inc = 1'b0;
      chk("clr_prio", 24'(score_bcd), 24'h000);
      chk("clr_sat", 24'(saturated), 24'h0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
